// File: rtl/fifo_collector.sv
// Host-side reader for the per-block result FIFOs: round-robin arbitration, serial
// request/capture of one WORD_BITS word per transfer, one-entry valid/ready output slot.
module fifo_collector #(
    parameter int unsigned N_BLOCKS   = 12,
    parameter int unsigned WORD_BITS  = 64,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned SETTLE     = 2
) (
    input  logic                 fifo_clk,
    input  logic                 fifo_rst_n,
    input  logic [N_BLOCKS:1]    enable,
    input  logic [N_BLOCKS:1]    fifo_empty,
    output logic [N_BLOCKS:1]    fifo_req,
    input  logic                 fifo_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic [3:0]           out_src,
    output logic                 busy,
    output logic [15:0]          word_count
);

    localparam int unsigned CntW = $clog2(WORD_BITS);
    localparam logic [CntW-1:0] WordLast = CntW'(WORD_BITS - 1);
    localparam logic [2:0] SetLast = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StReq, StCapture, StSettle} state_e;

    state_e                state_q, state_d;
    logic [3:0]            ptr_q, ptr_d;
    logic [3:0]            idx_q, idx_d;
    logic [CntW-1:0]       req_cnt_q, req_cnt_d;
    logic [CntW-1:0]       cap_cnt_q, cap_cnt_d;
    logic [2:0]            set_cnt_q, set_cnt_d;
    logic [RD_LATENCY-1:0] strb_q, strb_d;
    logic [WORD_BITS-1:0]  shreg_q, shreg_d;
    logic [N_BLOCKS:1]     fifo_req_q, fifo_req_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_BITS-1:0]  out_data_q, out_data_d;
    logic [3:0]            out_src_q, out_src_d;
    logic [15:0]           word_count_q, word_count_d;

    logic [N_BLOCKS:1] cand;
    logic              pick_found;
    logic [3:0]        pick_idx;
    logic [3:0]        blk;
    logic              shift_en;
    logic              handshake;

    // Round-robin scan starting just after the last served block.
    always_comb begin
        cand       = enable & ~fifo_empty;
        pick_found = 1'b0;
        pick_idx   = '0;
        blk        = '0;
        for (int unsigned off = 1; off <= N_BLOCKS; off++) begin
            blk = 4'(((32'(ptr_q) - 1 + off) % N_BLOCKS) + 1);
            if (!pick_found && cand[blk]) begin
                pick_found = 1'b1;
                pick_idx   = blk;
            end
        end
    end

    assign shift_en  = strb_q[RD_LATENCY-1];
    assign handshake = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        req_cnt_d    = req_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        set_cnt_d    = set_cnt_q;
        shreg_d      = shreg_q;
        fifo_req_d   = fifo_req_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        word_count_d = word_count_q;

        // Delay line aligning the request strobe with the returning bit.
        strb_d    = strb_q;
        strb_d[0] = (state_q == StReq);
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            strb_d[i] = strb_q[i-1];
        end

        if (handshake) begin
            out_valid_d  = 1'b0;
            word_count_d = word_count_q + 16'd1;
        end

        if (shift_en) begin
            shreg_d   = {shreg_q[WORD_BITS-2:0], fifo_bit};
            cap_cnt_d = cap_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (pick_found && (!out_valid_q || out_ready)) begin
                    idx_d                = pick_idx;
                    fifo_req_d           = '0;
                    fifo_req_d[pick_idx] = 1'b1;
                    req_cnt_d            = '0;
                    cap_cnt_d            = '0;
                    state_d              = StReq;
                end
            end
            StReq: begin
                req_cnt_d = req_cnt_q + CntW'(1);
                if (req_cnt_q == WordLast) begin
                    fifo_req_d = '0;
                    state_d    = StCapture;
                end
            end
            StCapture: begin
                if (shift_en && cap_cnt_q == WordLast) begin
                    out_valid_d = 1'b1;
                    out_data_d  = shreg_d;
                    out_src_d   = idx_q;
                    ptr_d       = idx_q;
                    set_cnt_d   = '0;
                    state_d     = (SETTLE == 0) ? StIdle : StSettle;
                end
            end
            StSettle: begin
                set_cnt_d = set_cnt_q + 3'd1;
                if (set_cnt_q == SetLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (!fifo_rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= 4'(N_BLOCKS);
            idx_q        <= '0;
            req_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            set_cnt_q    <= '0;
            strb_q       <= '0;
            shreg_q      <= '0;
            fifo_req_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            req_cnt_q    <= req_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            set_cnt_q    <= set_cnt_d;
            strb_q       <= strb_d;
            shreg_q      <= shreg_d;
            fifo_req_q   <= fifo_req_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            word_count_q <= word_count_d;
        end
    end

    assign fifo_req   = fifo_req_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign busy       = (state_q != StIdle);
    assign word_count = word_count_q;

endmodule
